// File: rtl/cnt1_arbiter_if.sv
// Handshake bundle between the two vector sources, the arbiter and the
// popcount stage. The arbiter uses the slave view; whatever feeds the sources
// and consumes the popcount-side beats uses the master view.
interface cnt1_arbiter_if #(
   parameter int BUS_WIDTH    = 128,
   parameter int VEC_ID_WIDTH = 16
);
   logic [BUS_WIDTH-1:0]    a_Vector;
   logic [VEC_ID_WIDTH-1:0] a_ID;
   logic                    a_Valid;
   logic                    a_Last;
   logic                    a_Ready;

   logic [BUS_WIDTH-1:0]    b_Vector;
   logic [VEC_ID_WIDTH-1:0] b_ID;
   logic                    b_Valid;
   logic                    b_Last;
   logic                    b_Ready;

   logic [BUS_WIDTH-1:0]    dn_Vector;
   logic [VEC_ID_WIDTH-1:0] dn_ID;
   logic                    dn_Src;
   logic                    dn_Valid;
   logic                    dn_Last;
   logic                    dn_Ready;

   modport master (
      output a_Vector, a_ID, a_Valid, a_Last,
      output b_Vector, b_ID, b_Valid, b_Last,
      input  a_Ready, b_Ready,
      input  dn_Vector, dn_ID, dn_Src, dn_Valid, dn_Last,
      output dn_Ready
   );

   modport slave (
      input  a_Vector, a_ID, a_Valid, a_Last,
      input  b_Vector, b_ID, b_Valid, b_Last,
      output a_Ready, b_Ready,
      output dn_Vector, dn_ID, dn_Src, dn_Valid, dn_Last,
      input  dn_Ready
   );
endinterface

// File: rtl/cnt1_arbiter.sv
// Vector-granular round-robin arbiter in front of the popcount stage.
// A grant lasts for a whole vector (SUB_VECTOR_NO beats) so sub-vectors of
// the two sources never interleave; the winner is tagged on dn_Src and a
// merged end-of-batch flag is produced once both sources have sent Last.
module cnt1_arbiter #(
   parameter int VECTOR_WIDTH  = 920,
   parameter int BUS_WIDTH     = 128,
   parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
   parameter int VEC_ID_WIDTH  = 16
) (
   input logic           clk,
   input logic           rstn,
   cnt1_arbiter_if.slave bus
);
   localparam int BEAT_CNT_WIDTH = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
   localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(SUB_VECTOR_NO - 1);

   typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

   state_t                    state;
   logic [BEAT_CNT_WIDTH-1:0] r_Beat;
   logic                      r_LastWinner;
   logic                      r_DoneA;
   logic                      r_DoneB;

   logic [BUS_WIDTH-1:0]      r_dnVector;
   logic [VEC_ID_WIDTH-1:0]   r_dnId;
   logic                      r_dnSrc;
   logic                      r_dnValid;
   logic                      r_dnLast;

   logic                      load_en;
   logic                      xfer_a;
   logic                      xfer_b;
   logic                      xfer;
   logic                      final_beat;
   logic                      sel_last;
   logic                      dn_last_next;
   logic                      done_a_next;
   logic                      done_b_next;
   logic                      req_a;
   logic                      req_b;
   logic                      arb_en;
   logic                      grant_a;
   logic                      grant_b;
   logic [BUS_WIDTH-1:0]      sel_vector;
   logic [VEC_ID_WIDTH-1:0]   sel_id;

   // Handshake, end-of-vector / end-of-batch detection and the next grant.
   // Done flags are looked at in their post-update form so a source that just
   // finished its last vector is already masked at the grant-switch edge.
   always_comb begin
      load_en      = !r_dnValid || bus.dn_Ready;
      xfer_a       = (state == GRANT_A) && load_en && bus.a_Valid;
      xfer_b       = (state == GRANT_B) && load_en && bus.b_Valid;
      xfer         = xfer_a || xfer_b;
      final_beat   = (r_Beat == LAST_BEAT);
      sel_vector   = xfer_b ? bus.b_Vector : bus.a_Vector;
      sel_id       = xfer_b ? bus.b_ID : bus.a_ID;
      sel_last     = xfer && final_beat && (xfer_b ? bus.b_Last : bus.a_Last);
      dn_last_next = sel_last && (xfer_b ? r_DoneA : r_DoneB);
      done_a_next  = r_DoneA;
      done_b_next  = r_DoneB;
      if (dn_last_next) begin
         done_a_next = 1'b0;
         done_b_next = 1'b0;
      end else if (sel_last) begin
         if (xfer_b) begin
            done_b_next = 1'b1;
         end else begin
            done_a_next = 1'b1;
         end
      end
      req_a   = bus.a_Valid && !done_a_next;
      req_b   = bus.b_Valid && !done_b_next;
      arb_en  = load_en && ((state == IDLE) || (xfer && final_beat));
      grant_a = req_a && (!req_b || r_LastWinner);
      grant_b = req_b && (!req_a || !r_LastWinner);
   end

   // Ready only opens towards the granted source, and only when the output
   // register is free to take the beat.
   assign bus.a_Ready   = load_en && (state == GRANT_A);
   assign bus.b_Ready   = load_en && (state == GRANT_B);
   assign bus.dn_Vector = r_dnVector;
   assign bus.dn_ID     = r_dnId;
   assign bus.dn_Src    = r_dnSrc;
   assign bus.dn_Valid  = r_dnValid;
   assign bus.dn_Last   = r_dnLast;

   // Grant FSM, beat counter, batch bookkeeping and the output register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         r_Beat       <= '0;
         r_LastWinner <= 1'b1;
         r_DoneA      <= 1'b0;
         r_DoneB      <= 1'b0;
         r_dnVector   <= '0;
         r_dnId       <= '0;
         r_dnSrc      <= 1'b0;
         r_dnValid    <= 1'b0;
         r_dnLast     <= 1'b0;
      end else begin
         r_DoneA <= done_a_next;
         r_DoneB <= done_b_next;
         if (xfer) begin
            r_Beat <= final_beat ? '0 : r_Beat + BEAT_CNT_WIDTH'(1);
         end
         if (arb_en) begin
            if (grant_a) begin
               state        <= GRANT_A;
               r_LastWinner <= 1'b0;
            end else if (grant_b) begin
               state        <= GRANT_B;
               r_LastWinner <= 1'b1;
            end else begin
               state <= IDLE;
            end
         end
         if (load_en) begin
            if (xfer) begin
               r_dnVector <= sel_vector;
               r_dnId     <= sel_id;
               r_dnSrc    <= xfer_b;
               r_dnValid  <= 1'b1;
               r_dnLast   <= dn_last_next;
            end else begin
               r_dnValid <= 1'b0;
               r_dnLast  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_cnt1_arbiter.sv
// Directed bench for cnt1_arbiter: per-source drivers feed hand-ordered
// vectors, the expected downstream beat order is queued up front and a
// monitor pops one entry per accepted downstream beat.
module tb_cnt1_arbiter;
   localparam int SUB = 8;

   typedef struct {
      logic [15:0] id;
      logic        last;
      int          startDelay;
      int          gapAfter;
      int          gapCycles;
   } vec_t;

   typedef struct {
      logic        src;
      logic [15:0] id;
      int          beat;
      logic        last;
   } exp_t;

   logic clk;
   logic rstn;
   vec_t vecA[$];
   vec_t vecB[$];
   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   cycleCnt = 0;
   int   xferCount = 0;
   int   firstCycle = 0;
   int   lastCycle = 0;
   int   startCycle = 0;
   bit   abortDrv = 1'b0;

   cnt1_arbiter_if #(.BUS_WIDTH(128), .VEC_ID_WIDTH(16)) bus ();

   cnt1_arbiter dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   // Free-running clock and a posedge counter used for latency/gap checks.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cycleCnt++;
      end
   end

   // Unique, decodable payload per (source, id, beat).
   function automatic logic [127:0] beatData(input logic src, input logic [15:0] id, input int beat);
      return {src ? 32'hBBBB_0000 : 32'hAAAA_0000, 16'h0000, id, 32'(beat), 32'h1234_5678 ^ {16'h0000, id}};
   endfunction

   function automatic vec_t mkVec(input int id, input bit last, input int startDelay,
                                  input int gapAfter, input int gapCycles);
      vec_t v;
      v.id = 16'(id);
      v.last = last;
      v.startDelay = startDelay;
      v.gapAfter = gapAfter;
      v.gapCycles = gapCycles;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic pushVector(input logic src, input int id, input bit lastOnFinal);
      exp_t e;
      for (int b = 0; b < SUB; b++) begin
         e.src = src;
         e.id = 16'(id);
         e.beat = b;
         e.last = lastOnFinal && (b == SUB - 1);
         sbq.push_back(e);
      end
   endtask

   task automatic setSource(input bit isB, input logic valid, input logic [127:0] vec,
                            input logic [15:0] id, input logic last);
      if (isB) begin
         bus.b_Valid = valid;
         bus.b_Vector = vec;
         bus.b_ID = id;
         bus.b_Last = last;
      end else begin
         bus.a_Valid = valid;
         bus.a_Vector = vec;
         bus.a_ID = id;
         bus.a_Last = last;
      end
   endtask

   // Plays one source's vector list; Last is held on every beat so the
   // arbiter has to ignore it on non-final beats.
   task automatic applyStimulus(input bit isB);
      vec_t list[$];
      int   waited;
      bit   done;
      if (isB) list = vecB;
      else list = vecA;
      foreach (list[v]) begin
         for (int d = 0; d < list[v].startDelay; d++) begin
            @(posedge clk);
            #1;
         end
         for (int beat = 0; beat < SUB; beat++) begin
            setSource(isB, 1'b1, beatData(isB, list[v].id, beat), list[v].id, list[v].last);
            done = 1'b0;
            waited = 0;
            while (!done) begin
               @(negedge clk);
               done = isB ? (bus.b_Valid && bus.b_Ready) : (bus.a_Valid && bus.a_Ready);
               @(posedge clk);
               #1;
               if (abortDrv) begin
                  setSource(isB, 1'b0, '0, '0, 1'b0);
                  return;
               end
               waited++;
               if (!done && waited > 300) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL handshake_timeout src=%0d id=%0d beat=%0d: waited %0d cycles, required <= 300",
                           isB, list[v].id, beat, waited);
                  setSource(isB, 1'b0, '0, '0, 1'b0);
                  return;
               end
            end
            if (beat == list[v].gapAfter && list[v].gapCycles > 0) begin
               setSource(isB, 1'b0, '0, '0, 1'b0);
               for (int g = 0; g < list[v].gapCycles; g++) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
      end
      setSource(isB, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic checkResetState();
      checkOutput("reset dn_Valid", 128'(bus.dn_Valid), 128'(0));
      checkOutput("reset dn_Last", 128'(bus.dn_Last), 128'(0));
      checkOutput("reset dn_Src", 128'(bus.dn_Src), 128'(0));
      checkOutput("reset dn_Vector", bus.dn_Vector, 128'(0));
      checkOutput("reset dn_ID", 128'(bus.dn_ID), 128'(0));
      checkOutput("reset a_Ready", 128'(bus.a_Ready), 128'(0));
      checkOutput("reset b_Ready", 128'(bus.b_Ready), 128'(0));
   endtask

   task automatic applyReset(input bit checkState);
      abortDrv = 1'b0;
      bus.dn_Ready = 1'b1;
      setSource(1'b0, 1'b0, '0, '0, 1'b0);
      setSource(1'b1, 1'b0, '0, '0, 1'b0);
      rstn = 1'b0;
      #1;
      if (checkState) checkResetState();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      xferCount = 0;
      startCycle = cycleCnt;
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (sbq.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      checkOutput({name, " beats left undelivered"}, 128'(sbq.size()), 128'(0));
      sbq.delete();
   endtask

   // Scoreboard monitor: every beat accepted downstream must match the head
   // of the expected queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && bus.dn_Valid && bus.dn_Ready) begin
            xferCount++;
            if (xferCount == 1) firstCycle = cycleCnt;
            lastCycle = cycleCnt;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_beat: got src=%0d id=%0d vector=%h, required no beat",
                        bus.dn_Src, bus.dn_ID, bus.dn_Vector);
            end else begin
               e = sbq.pop_front();
               checkOutput($sformatf("beat src%0d id%0d b%0d vector", e.src, e.id, e.beat),
                           bus.dn_Vector, beatData(e.src, e.id, e.beat));
               checkOutput($sformatf("beat src%0d id%0d b%0d {src,id,last}", e.src, e.id, e.beat),
                           128'({bus.dn_Src, bus.dn_ID, bus.dn_Last}), 128'({e.src, e.id, e.last}));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rstn = 1'b1;
      #3;
      applyReset(1'b1);

      // Single source, two back-to-back vectors.
      vecA.delete(); vecB.delete();
      vecA.push_back(mkVec(5, 0, 0, -1, 0));
      vecA.push_back(mkVec(6, 0, 0, -1, 0));
      pushVector(1'b0, 5, 0);
      pushVector(1'b0, 6, 0);
      applyStimulus(1'b0);
      waitDrain("single");
      checkOutput("single first-beat latency", 128'(firstCycle - startCycle), 128'(2));
      checkOutput("single span", 128'(lastCycle - firstCycle), 128'(15));

      // Tie after reset: A first, then strict alternation with no gap.
      applyReset(1'b0);
      vecA.delete(); vecB.delete();
      vecA.push_back(mkVec(1, 0, 0, -1, 0));
      vecA.push_back(mkVec(2, 0, 0, -1, 0));
      vecB.push_back(mkVec(3, 0, 0, -1, 0));
      vecB.push_back(mkVec(4, 0, 0, -1, 0));
      pushVector(1'b0, 1, 0);
      pushVector(1'b1, 3, 0);
      pushVector(1'b0, 2, 0);
      pushVector(1'b1, 4, 0);
      fork
         applyStimulus(1'b0);
         applyStimulus(1'b1);
      join
      waitDrain("tie");
      checkOutput("tie first-beat latency", 128'(firstCycle - startCycle), 128'(2));
      checkOutput("tie span", 128'(lastCycle - firstCycle), 128'(31));

      // Downstream backpressure for three cycles while beat 4 is held.
      applyReset(1'b0);
      vecA.delete(); vecB.delete();
      vecA.push_back(mkVec(7, 0, 0, -1, 0));
      pushVector(1'b0, 7, 0);
      fork
         applyStimulus(1'b0);
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(bus.dn_Valid && bus.dn_Vector == beatData(1'b0, 16'd7, 3)) && n < 100);
            checkOutput("backpressure beat3 seen", 128'(bus.dn_Vector), beatData(1'b0, 16'd7, 3));
            @(posedge clk);
            #1;
            bus.dn_Ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               checkOutput($sformatf("backpressure c%0d dn_Vector", c), bus.dn_Vector, beatData(1'b0, 16'd7, 4));
               checkOutput($sformatf("backpressure c%0d dn_Valid", c), 128'(bus.dn_Valid), 128'(1));
               checkOutput($sformatf("backpressure c%0d a_Ready", c), 128'(bus.a_Ready), 128'(0));
            end
            @(posedge clk);
            #1;
            bus.dn_Ready = 1'b1;
         end
      join
      waitDrain("backpressure");

      // B stalls mid-vector; A must wait for B's final beat.
      applyReset(1'b0);
      vecA.delete(); vecB.delete();
      vecB.push_back(mkVec(30, 0, 0, 3, 4));
      vecA.push_back(mkVec(31, 0, 3, -1, 0));
      pushVector(1'b1, 30, 0);
      pushVector(1'b0, 31, 0);
      fork
         applyStimulus(1'b0);
         applyStimulus(1'b1);
      join
      waitDrain("stall");
      checkOutput("stall span", 128'(lastCycle - firstCycle), 128'(19));

      // Batch end: dn_Last only on B's final beat once A is done.
      applyReset(1'b0);
      vecA.delete(); vecB.delete();
      vecA.push_back(mkVec(10, 1, 0, -1, 0));
      vecA.push_back(mkVec(11, 0, 0, -1, 0));
      vecB.push_back(mkVec(20, 1, 0, -1, 0));
      pushVector(1'b0, 10, 0);
      pushVector(1'b1, 20, 1);
      pushVector(1'b0, 11, 0);
      fork
         applyStimulus(1'b0);
         applyStimulus(1'b1);
      join
      waitDrain("batch");
      checkOutput("batch span", 128'(lastCycle - firstCycle), 128'(23));

      // Asynchronous reset in the middle of a vector.
      applyReset(1'b0);
      vecA.delete(); vecB.delete();
      vecA.push_back(mkVec(40, 0, 0, -1, 0));
      for (int b = 0; b < 5; b++) begin
         exp_t e;
         e.src = 1'b0;
         e.id = 16'd40;
         e.beat = b;
         e.last = 1'b0;
         sbq.push_back(e);
      end
      fork
         applyStimulus(1'b0);
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(bus.dn_Valid && bus.dn_Vector == beatData(1'b0, 16'd40, 4)) && n < 100);
            checkOutput("midreset beat4 seen", bus.dn_Vector, beatData(1'b0, 16'd40, 4));
            #2;
            rstn = 1'b0;
            abortDrv = 1'b1;
            #1;
            checkResetState();
         end
      join
      checkOutput("midreset beats left undelivered", 128'(sbq.size()), 128'(0));
      sbq.delete();
      applyReset(1'b0);
      vecA.delete(); vecB.delete();
      vecA.push_back(mkVec(41, 0, 0, -1, 0));
      vecB.push_back(mkVec(42, 0, 0, -1, 0));
      pushVector(1'b0, 41, 0);
      pushVector(1'b1, 42, 0);
      fork
         applyStimulus(1'b0);
         applyStimulus(1'b1);
      join
      waitDrain("post-reset");
      checkOutput("post-reset first-beat latency", 128'(firstCycle - startCycle), 128'(2));
      checkOutput("post-reset span", 128'(lastCycle - firstCycle), 128'(15));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cnt1_arbiter.md
# cnt1_arbiter

Two-input, vector-granular round-robin arbiter that shares one popcount pipeline between a reference-vector stream (source A) and a query-vector stream (source B). Grants are held for exactly SUB_VECTOR_NO accepted beats, so the popcount stage's word counter never sees interleaved sub-vectors. The winning source is tagged on a sideband bit, and a merged end-of-batch Last is produced. It sits directly upstream of the popcount stage and drives its up_* port from a single output register.

## Interface
- VECTOR_WIDTH, 920: full fingerprint width in bits.
- BUS_WIDTH, 128: sub-vector (beat) width.
- SUB_VECTOR_NO, ceil(VECTOR_WIDTH/BUS_WIDTH): beats per vector; must be ≥1.
- VEC_ID_WIDTH, 16: vector ID width.
- BEAT_CNT_WIDTH, max(1,$clog2(SUB_VECTOR_NO)): beat counter width (derived).

- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- a_Vector / b_Vector  in  BUS_WIDTH  sub-vector from source A / B.
- a_ID / b_ID  in  VEC_ID_WIDTH  vector ID, constant across a vector's beats.
- a_Valid / b_Valid  in  1  beat valid.
- a_Last / b_Last  in  1  source's final vector; sampled only on a vector's final beat.
- a_Ready / b_Ready  out  1  beat accepted when Valid&&Ready.
- dn_Vector  out  BUS_WIDTH  registered sub-vector to popcount stage.
- dn_ID  out  VEC_ID_WIDTH  registered ID.
- dn_Src  out  1  0 = source A, 1 = source B (routed into popcount sideband).
- dn_Valid  out  1  registered valid.
- dn_Last  out  1  final beat of the batch's last vector.
- dn_Ready  in  1  downstream ready.

## Operation
- FSM states: IDLE, GRANT_A, GRANT_B. Beat counter r_Beat counts accepted beats within the current grant.
- Output register loads when load_en = !dn_Valid || dn_Ready.
- a_Ready = load_en && state==GRANT_A; b_Ready = load_en && state==GRANT_B. Both Ready are 0 in IDLE.
- A beat transfer (granted Valid && Ready) loads dn_Vector/dn_ID/dn_Src and sets dn_Valid=1.
- If load_en holds with no transfer, dn_Valid is cleared.
- r_Beat increments on each transfer. On the transfer where r_Beat==SUB_VECTOR_NO-1 (the final beat), r_Beat←0 and the next grant is chosen.
- If SUB_VECTOR_NO==1, every beat is a final beat.
- Arbitration (in IDLE each cycle, or at a final-beat transfer):
  - Only one of a_Valid/b_Valid high → that source wins.
  - Both high → the source not in r_LastWinner wins.
  - Neither high → IDLE.
  - r_LastWinner updates on every grant decision.
- A source whose done flag is set is masked out of arbitration.
- Done flags r_DoneA/r_DoneB are set on a final-beat transfer with that source's Last=1.
- dn_Last is registered with the beat. It equals 1 when the beat is a final beat, the source's Last=1, and the other source is already done (or is completing simultaneously, which is impossible by construction).
- When a beat with dn_Last=1 transfers, both done flags clear on that cycle, starting a new batch.
- Last asserted on a non-final beat is ignored (not propagated, no flag change).
- A grant is never revoked mid-vector. A source that drops Valid mid-vector stalls the arbiter in its GRANT state.

## Timing
- Reset (async assert, sync-style deassert): state=IDLE, r_Beat=0, r_LastWinner=B (so A wins the first tie), done flags=0, dn_Valid=0, dn_Last=0, dn_Src=0, dn_Vector=0, dn_ID=0, a_Ready=b_Ready=0.
- IDLE→GRANT costs one cycle: Ready rises the cycle after Valid is seen in IDLE.
- Latency from input transfer to dn_Valid is 1 cycle.
- Back-to-back vectors from alternating or the same source incur no bubble: the grant switches at the final-beat edge.
- Full throughput: with dn_Ready=1 held, 1 beat/cycle.
- With dn_Ready=0 and dn_Valid=1: outputs hold stable, both Ready=0, FSM and r_Beat frozen.
- Reset mid-vector discards the partial vector. The popcount stage is reset by the same rstn.

## Test plan
- Single source: A sends 2 vectors (IDs 5, 6) × 8 beats, dn_Ready=1 → dn beats 16 consecutive cycles starting 2 cycles after a_Valid, dn_Src=0, dn_ID 5×8 then 6×8, dn_Last=0.
- Tie after reset: A and B both valid from cycle 0 → order is A(8 beats), B(8), A(8), B(8), with no gap between vectors and dn_Src toggling every 8 beats.
- Backpressure: dn_Ready=0 for 3 cycles mid-vector at beat 4 → dn_Vector/dn_ID stable, a_Ready=0, no beat lost or duplicated, r_Beat resumes at 5.
- Mid-vector stall: B drops b_Valid after beat 3 while A is valid → grant stays B, A not served until B's 8th beat transfers.
- Batch end: A Last on vector ID 10 final beat, then B Last on ID 20 final beat → dn_Last=1 only on ID 20 beat 7. After that, A is arbitrable again and its next vector is served.
- Async reset at beat 5 of a vector → all outputs 0 within the reset assertion. After release, the next vector starts at beat 0 and A wins a tie.
